// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard/flush controller: debug FSM states
// and pipeline stage indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } dbg_state_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16
);
    logic                  run_en;
    logic                  step;
    logic [REG_AW-1:0]     id_rs;
    logic [REG_AW-1:0]     id_rt;
    logic                  id_uses_rt;
    logic                  ex_memread;
    logic [REG_AW-1:0]     ex_rt;
    logic                  mem_busy;
    logic                  redirect;
    logic                  pc_write;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  halted;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output run_en, step, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               mem_busy, redirect,
        input  pc_write, stage_en, stage_flush, halted, stall_count, flush_count
    );

    modport slave (
        input  run_en, step, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               mem_busy, redirect,
        output pc_write, stage_en, stage_flush, halted, stall_count, flush_count
    );
endinterface

// File: rtl/pipe_step_fsm.sv
// Run/halt/single-step debug FSM with a registered rising-edge detector on step.
module pipe_step_fsm
    import pipe_pkg::*;
#(
    parameter bit START_HALTED = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_en,
    input  logic       step,
    input  logic       mem_busy,
    output dbg_state_t state
);
    localparam dbg_state_t RESET_STATE = START_HALTED ? HALT : RUN;

    dbg_state_t next_state;
    logic       step_q;
    logic       step_rise;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RESET_STATE;
            step_q <= 1'b0;
        end else begin
            state  <= next_state;
            step_q <= step;
        end
    end

    // A step leaves STEP only once a non-frozen cycle has let the pipe advance.
    always_comb begin
        next_state = state;
        unique case (state)
            RUN:     if (!run_en) next_state = HALT;
            HALT: begin
                if (run_en)         next_state = RUN;
                else if (step_rise) next_state = STEP;
            end
            STEP:    if (!mem_busy) next_state = HALT;
            default: next_state = RESET_STATE;
        endcase
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: freeze / redirect-flush / load-use stall priority logic,
// debug FSM instance and saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int REG_AW       = 5,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16,
    parameter bit START_HALTED = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);
    dbg_state_t            state;
    logic                  load_use;
    logic                  freeze;
    logic                  redir_act;
    logic                  stall_act;
    logic [NUM_STAGES-1:0] en;
    logic [NUM_STAGES-1:0] flush;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pipe_step_fsm #(.START_HALTED(START_HALTED)) u_fsm (
        .clock    (clock),
        .reset    (reset),
        .run_en   (bus.run_en),
        .step     (bus.step),
        .mem_busy (bus.mem_busy),
        .state    (state)
    );

    assign load_use = bus.ex_memread && (bus.ex_rt != '0) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    assign freeze = (state == HALT) || bus.mem_busy;

    // With branches resolving in ID, the branch may itself be waiting on the load.
    assign redir_act = !freeze && bus.redirect && !((BRANCH_STAGE == 1) && load_use);
    assign stall_act = !freeze && !redir_act && load_use;

    always_comb begin
        en    = '1;
        flush = '0;
        if (freeze) begin
            en = '0;
        end else if (redir_act) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (k <= BRANCH_STAGE) flush[k] = 1'b1;
            end
        end else if (stall_act) begin
            en[STG_IF]    = 1'b0;
            en[STG_ID]    = 1'b0;
            flush[STG_EX] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state != HALT) && (bus.mem_busy || stall_act)) stall_cnt <= sat_inc(stall_cnt);
            if (redir_act) flush_cnt <= sat_inc(flush_cnt);
        end
    end

    assign bus.stage_en    = en;
    assign bus.stage_flush = flush;
    assign bus.pc_write    = en[STG_IF];
    assign bus.halted      = (state == HALT);
    assign bus.stall_count = stall_cnt;
    assign bus.flush_count = flush_cnt;
endmodule
